q_debounce: RTL and testbench
=============================

# q_debounce

Downstream consumer of the NAND-latch D flip-flop output pair. The block synchronizes the complementary `q`/`q_prim` outputs into the `clc` domain and rejects any pair that is not complementary. It commits a new level only after the input has been stable for a programmable number of cycles. Each committed change produces a one-cycle rise or fall pulse, and an optional counter tallies committed events.

## Interface
- `STABLE_CYCLES`, default 16: consecutive valid, equal samples required to commit a level; legal range 1..255.
- `CNT_W`, default 8: width of the event counter.
- `clc`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `q_in`  in  1  latch `q`, asynchronous to `clc`.
- `q_prim_in`  in  1  latch `q_prim`, asynchronous to `clc`.
- `cnt_clr`  in  1  synchronous clear of `evt_cnt`.
- `level`  out  1  debounced, committed level.
- `rise`  out  1  one-cycle pulse on a committed 0→1.
- `fall`  out  1  one-cycle pulse on a committed 1→0.
- `bad_pair`  out  1  high in every cycle the synchronized pair is non-complementary.
- `evt_cnt`  out  CNT_W  committed-event count.

## Operation
- Synchronizer: two flops per input.
  - Reset values: `q` path 0, `q_prim` path 1, so the pair is valid out of reset.
  - `s` denotes the second-stage `q` value.
  - `valid` = second-stage values differ.
- FSM states: ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW. Reset state is ST_LOW.
- Stability counter `stab` is ceil(log2(STABLE_CYCLES+1)) bits, reset 0.
- ST_LOW transitions:
  - `valid && s` → CHK_HIGH, `stab`=1.
  - If STABLE_CYCLES==1: → ST_HIGH directly and pulse `rise`.
- CHK_HIGH transitions:
  - `valid && s && stab==STABLE_CYCLES-1` → ST_HIGH, pulse `rise`, `stab`=0.
  - `valid && s` (count not yet reached) → `stab`++.
  - `valid && !s` → ST_LOW, `stab`=0. No pulse.
  - `!valid` → hold state and `stab`. An invalid pair neither counts nor aborts.
- ST_HIGH and CHK_LOW mirror the above with `!s`, and pulse `fall`.
- `level` = 1 in ST_HIGH and CHK_LOW, 0 otherwise. It is registered and glitch-free.
- `rise`, `fall` and `bad_pair` are registered. `rise` and `fall` are never high together.
- Event counter:
  - Increments by 1 on each `rise` or `fall` commit.
  - Wraps modulo 2^CNT_W.
  - `cnt_clr` has priority: a clear in the same cycle as a commit yields 0.

## Timing
- Reset values: `level`=0, `rise`=0, `fall`=0, `bad_pair`=0, `evt_cnt`=0, FSM in ST_LOW, `stab`=0.
- Asserting `rst_n` low mid-check discards the partial count immediately. There is no pulse on reset.
- Commit latency: if a change is first sampled at edge 1 and then held stable and valid, `level` and the pulse update at edge STABLE_CYCLES+2. Each invalid cycle in between adds one cycle.
- `bad_pair` follows the input pair with 3-edge latency: 2 synchronizer edges plus 1 output register.
- `evt_cnt` updates on the same edge as `level`. A `cnt_clr` sampled at edge k shows 0 after edge k.
- Continuous toggling faster than STABLE_CYCLES never commits. `level` holds its value.

## Configuration
- `QDEB_EVT_CNT_EN` defined:
  - Event counter is present as described.
- `QDEB_EVT_CNT_EN` undefined:
  - Counter logic is removed.
  - `evt_cnt` is tied to 0 and `cnt_clr` is ignored.
  - All other outputs behave identically.

## Test plan
- Reset (STABLE_CYCLES=4): hold `rst_n`=0, then release → all outputs 0 and `level` stays 0 with pair (0,1) held.
- Clean rise (STABLE_CYCLES=4): pair goes (1,0) before edge 1 and is held → `level`=1 and `rise`=1 for one cycle at edge 6; `evt_cnt`=1.
- Bounce (STABLE_CYCLES=4): from high, pair goes (0,1) for 2 cycles, back to (1,0), then (0,1) held → no `fall` during the bounce; `fall` at the 6th edge after the final change; `evt_cnt`=2.
- Invalid pair (STABLE_CYCLES=4): during CHK_HIGH, drive (1,1) for 3 cycles → `bad_pair` high 3 cycles; commit delayed by exactly 3 edges versus the clean case.
- Counter wrap and clear (CNT_W=2): 4 commits → `evt_cnt` goes 1,2,3,0; `cnt_clr` in the same cycle as a 5th commit → `evt_cnt`=0.
- Mid-check reset (STABLE_CYCLES=16): assert `rst_n` low at `stab`=10 → immediate ST_LOW, `stab`=0; after release with input still high, a full 18 edges are needed to commit.

Source files
------------

// File: rtl/q_debounce.sv
// ---------------------------------------------------------------------------
// q_debounce
//   Debounces the complementary q/q_prim pair of a NAND-latch D flip-flop
//   into the clc domain. Non-complementary pairs are flagged and ignored. A
//   new level is committed only after STABLE_CYCLES consecutive valid, equal
//   samples. Every commit produces a one-cycle rise or fall pulse.
//
//   Build option: define QDEB_EVT_CNT_EN to include the committed-event
//   counter. Without it, evt_cnt is tied to 0 and cnt_clr is ignored.
//
// Parameters
//   STABLE_CYCLES  consecutive valid equal samples needed to commit (1..255)
//   CNT_W          event counter width
// Ports
//   clc        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   q_in       in   latch q, asynchronous to clc
//   q_prim_in  in   latch q_prim, asynchronous to clc
//   cnt_clr    in   synchronous clear of evt_cnt (wins over an increment)
//   level      out  committed, debounced level
//   rise       out  one-cycle pulse on a committed 0->1
//   fall       out  one-cycle pulse on a committed 1->0
//   bad_pair   out  synchronized pair is non-complementary
//   evt_cnt    out  committed-event count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module q_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clc,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             q_prim_in,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             bad_pair,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  // Entering a CHK state already accounts for one sample, so the commit
  // happens when the counter has reached STABLE_CYCLES-1.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

  localparam logic [1:0] ST_LOW   = 2'd0;
  localparam logic [1:0] CHK_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] CHK_LOW  = 2'd3;

  // Two-flop synchronizers; reset to a valid (0,1) pair.
  logic q_meta_q,  q_meta_d;
  logic q_sync_q,  q_sync_d;
  logic qp_meta_q, qp_meta_d;
  logic qp_sync_q, qp_sync_d;

  always_comb begin
    q_meta_d  = q_in;
    q_sync_d  = q_meta_q;
    qp_meta_d = q_prim_in;
    qp_sync_d = qp_meta_q;
  end

  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
      qp_meta_q <= 1'b1;
      qp_sync_q <= 1'b1;
    end else begin
      q_meta_q  <= q_meta_d;
      q_sync_q  <= q_sync_d;
      qp_meta_q <= qp_meta_d;
      qp_sync_q <= qp_sync_d;
    end
  end

  logic s_c;
  logic valid_c;

  assign s_c     = q_sync_q;
  assign valid_c = q_sync_q ^ qp_sync_q;

  // Debounce FSM and stability counter.
  logic [1:0]        state_q, state_d;
  logic [STAB_W-1:0] stab_q,  stab_d;
  logic              level_q, level_d;
  logic              rise_q,  rise_d;
  logic              fall_q,  fall_d;
  logic              bad_pair_q, bad_pair_d;

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    bad_pair_d = !valid_c;

    // An invalid pair leaves state and count untouched in every state.
    case (state_q)
      ST_LOW: begin
        if (valid_c && s_c) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_HIGH;
            stab_d  = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = CHK_HIGH;
            stab_d  = STAB_ONE;
          end
        end
      end
      CHK_HIGH: begin
        if (valid_c) begin
          if (s_c) begin
            if (stab_q == STAB_LAST) begin
              state_d = ST_HIGH;
              stab_d  = '0;
              rise_d  = 1'b1;
            end else begin
              stab_d = stab_q + STAB_ONE;
            end
          end else begin
            // Bounced back before reaching the threshold: abort quietly.
            state_d = ST_LOW;
            stab_d  = '0;
          end
        end
      end
      ST_HIGH: begin
        if (valid_c && !s_c) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_LOW;
            stab_d  = '0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHK_LOW;
            stab_d  = STAB_ONE;
          end
        end
      end
      CHK_LOW: begin
        if (valid_c) begin
          if (!s_c) begin
            if (stab_q == STAB_LAST) begin
              state_d = ST_LOW;
              stab_d  = '0;
              fall_d  = 1'b1;
            end else begin
              stab_d = stab_q + STAB_ONE;
            end
          end else begin
            state_d = ST_HIGH;
            stab_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_LOW;
        stab_d  = '0;
      end
    endcase

    // Level is a registered decode of the next state, so it never glitches.
    level_d = (state_d == ST_HIGH) || (state_d == CHK_LOW);
  end

  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOW;
      stab_q     <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      bad_pair_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      bad_pair_q <= bad_pair_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign bad_pair = bad_pair_q;

`ifdef QDEB_EVT_CNT_EN
  // Committed-event counter; updates on the same edge as level.
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (cnt_clr) begin
      evt_cnt_d = '0;
    end else if (rise_d || fall_d) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign evt_cnt        = '0;
`endif

endmodule

// File: tb/tb_q_debounce.sv
// ---------------------------------------------------------------------------
// tb_q_debounce
//   Directed bench for q_debounce. Instance a: STABLE_CYCLES=4, CNT_W=2.
//   Instance b: STABLE_CYCLES=16, CNT_W=8 (mid-check reset).
//   Expected outputs are queued with the edge at which they are due and
//   checked one delay unit after that rising edge.
// ---------------------------------------------------------------------------
module tb_q_debounce;

  localparam int F_LEVEL = 0;
  localparam int F_RISE  = 1;
  localparam int F_FALL  = 2;
  localparam int F_BAD   = 3;
  localparam int F_CNT   = 4;

  logic clc = 1'b0;
  always #5 clc = ~clc;

  logic       rst_a_n, qa, qpa, clr_a;
  logic       level_a, rise_a, fall_a, bad_a;
  logic [1:0] cnt_a;

  logic       rst_b_n, qb, qpb, clr_b;
  logic       level_b, rise_b, fall_b, bad_b;
  logic [7:0] cnt_b;

  q_debounce #(.STABLE_CYCLES(4), .CNT_W(2)) u_a (
    .clc(clc), .rst_n(rst_a_n), .q_in(qa), .q_prim_in(qpa), .cnt_clr(clr_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .bad_pair(bad_a),
    .evt_cnt(cnt_a)
  );

  q_debounce #(.STABLE_CYCLES(16), .CNT_W(8)) u_b (
    .clc(clc), .rst_n(rst_b_n), .q_in(qb), .q_prim_in(qpb), .cnt_clr(clr_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .bad_pair(bad_b),
    .evt_cnt(cnt_b)
  );

  typedef struct {
    int         at;
    int         dut;
    int         fld;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   chks = 0;
  int   errs = 0;

  function automatic logic [7:0] exp_cnt(input int v);
`ifdef QDEB_EVT_CNT_EN
    return 8'(v);
`else
    return 8'(0 * v);
`endif
  endfunction

  function automatic logic [7:0] obs(input int dut, input int fld);
    logic [7:0] r;
    r = 8'hxx;
    if (dut == 0) begin
      case (fld)
        F_LEVEL: r = 8'(level_a);
        F_RISE:  r = 8'(rise_a);
        F_FALL:  r = 8'(fall_a);
        F_BAD:   r = 8'(bad_a);
        default: r = 8'(cnt_a);
      endcase
    end else begin
      case (fld)
        F_LEVEL: r = 8'(level_b);
        F_RISE:  r = 8'(rise_b);
        F_FALL:  r = 8'(fall_b);
        F_BAD:   r = 8'(bad_b);
        default: r = cnt_b;
      endcase
    end
    return r;
  endfunction

  task automatic expect_span(input int dut, input int fld, input int from,
                             input int to, input logic [7:0] v,
                             input string tag);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.at  = cyc + k;
      e.dut = dut;
      e.fld = fld;
      e.val = v;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic expect_idle(input int dut, input int from, input int to,
                             input string tag);
    expect_span(dut, F_LEVEL, from, to, 8'd0, {tag, "_level"});
    expect_span(dut, F_RISE,  from, to, 8'd0, {tag, "_rise"});
    expect_span(dut, F_FALL,  from, to, 8'd0, {tag, "_fall"});
    expect_span(dut, F_BAD,   from, to, 8'd0, {tag, "_bad"});
    expect_span(dut, F_CNT,   from, to, 8'd0, {tag, "_cnt"});
  endtask

  task automatic check_due();
    int         i;
    logic [7:0] o;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at <= cyc) begin
        o = obs(sb[i].dut, sb[i].fld);
        chks++;
        assert (o === sb[i].val) else begin
          errs++;
          $error("FAIL %s edge %0d observed %0h expected %0h",
                 sb[i].tag, cyc, o, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_val(input string tag, input int o, input int e);
    chks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clc);
      #1;
      cyc++;
      check_due();
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    qa = 1'b0; qpa = 1'b1; clr_a = 1'b0;
    qb = 1'b0; qpb = 1'b1; clr_b = 1'b0;

    // Reset held, then released with the pair parked at (0,1).
    expect_idle(0, 1, 3, "a_rst");
    expect_idle(1, 1, 3, "b_rst");
    step(3);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    expect_idle(0, 1, 6, "a_idle");
    expect_idle(1, 1, 6, "b_idle");
    step(6);

    // Clean rise: commit at edge 6.
    qa = 1'b1; qpa = 1'b0;
    expect_span(0, F_LEVEL, 1, 5, 8'd0, "a_clean_level");
    expect_span(0, F_LEVEL, 6, 7, 8'd1, "a_clean_level");
    expect_span(0, F_RISE,  1, 5, 8'd0, "a_clean_rise");
    expect_span(0, F_RISE,  6, 6, 8'd1, "a_clean_rise");
    expect_span(0, F_RISE,  7, 7, 8'd0, "a_clean_rise");
    expect_span(0, F_FALL,  1, 7, 8'd0, "a_clean_fall");
    expect_span(0, F_BAD,   1, 7, 8'd0, "a_clean_bad");
    expect_span(0, F_CNT,   5, 5, exp_cnt(0), "a_clean_cnt");
    expect_span(0, F_CNT,   6, 6, exp_cnt(1), "a_clean_cnt");
    step(7);

    // Bounce: low 2, high 1, then low held; fall 6 edges after final change.
    qa = 1'b0; qpa = 1'b1;
    expect_span(0, F_LEVEL, 1, 8,  8'd1, "a_bounce_level");
    expect_span(0, F_LEVEL, 9, 10, 8'd0, "a_bounce_level");
    expect_span(0, F_FALL,  1, 8,  8'd0, "a_bounce_fall");
    expect_span(0, F_FALL,  9, 9,  8'd1, "a_bounce_fall");
    expect_span(0, F_FALL,  10, 10, 8'd0, "a_bounce_fall");
    expect_span(0, F_RISE,  1, 10, 8'd0, "a_bounce_rise");
    expect_span(0, F_CNT,   8, 8, exp_cnt(1), "a_bounce_cnt");
    expect_span(0, F_CNT,   9, 9, exp_cnt(2), "a_bounce_cnt");
    step(2);
    qa = 1'b1; qpa = 1'b0;
    step(1);
    qa = 1'b0; qpa = 1'b1;
    step(7);

    // Invalid (1,1) for 3 samples during CHK_HIGH delays the commit by 3.
    qa = 1'b1; qpa = 1'b0;
    expect_span(0, F_LEVEL, 1, 8,  8'd0, "a_inv_level");
    expect_span(0, F_LEVEL, 9, 10, 8'd1, "a_inv_level");
    expect_span(0, F_RISE,  1, 8,  8'd0, "a_inv_rise");
    expect_span(0, F_RISE,  9, 9,  8'd1, "a_inv_rise");
    expect_span(0, F_RISE,  10, 10, 8'd0, "a_inv_rise");
    expect_span(0, F_BAD,   1, 5,  8'd0, "a_inv_bad");
    expect_span(0, F_BAD,   6, 8,  8'd1, "a_inv_bad");
    expect_span(0, F_BAD,   9, 10, 8'd0, "a_inv_bad");
    expect_span(0, F_CNT,   8, 8, exp_cnt(2), "a_inv_cnt");
    expect_span(0, F_CNT,   9, 9, exp_cnt(3), "a_inv_cnt");
    step(3);
    qpa = 1'b1;
    step(3);
    qpa = 1'b0;
    step(4);

    // Fourth commit wraps the 2-bit counter to 0.
    qa = 1'b0; qpa = 1'b1;
    expect_span(0, F_LEVEL, 5, 5, 8'd1, "a_wrap_level");
    expect_span(0, F_LEVEL, 6, 6, 8'd0, "a_wrap_level");
    expect_span(0, F_FALL,  6, 6, 8'd1, "a_wrap_fall");
    expect_span(0, F_CNT,   5, 5, exp_cnt(3), "a_wrap_cnt");
    expect_span(0, F_CNT,   6, 6, exp_cnt(0), "a_wrap_cnt");
    step(7);

    // Fifth commit with cnt_clr on the same edge: clear wins.
    qa = 1'b1; qpa = 1'b0;
    expect_span(0, F_RISE, 6, 6, 8'd1, "a_clr_rise");
    expect_span(0, F_CNT,  5, 5, exp_cnt(0), "a_clr_cnt");
    expect_span(0, F_CNT,  6, 7, exp_cnt(0), "a_clr_cnt");
    step(5);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    step(1);

    // Sixth commit counts normally, then a standalone clear.
    qa = 1'b0; qpa = 1'b1;
    expect_span(0, F_FALL, 6, 6, 8'd1, "a_post_fall");
    expect_span(0, F_CNT,  6, 7, exp_cnt(1), "a_post_cnt");
    step(7);
    clr_a = 1'b1;
    expect_span(0, F_CNT, 1, 1, exp_cnt(0), "a_solo_clr_cnt");
    step(1);
    clr_a = 1'b0;

    // Mid-check reset on the 16-cycle instance at stab=10.
    qb = 1'b1; qpb = 1'b0;
    expect_span(1, F_LEVEL, 1, 12, 8'd0, "b_pre_level");
    expect_span(1, F_RISE,  1, 12, 8'd0, "b_pre_rise");
    step(12);
    check_val("b_stab_before_rst", int'(u_b.stab_q), 10);
    rst_b_n = 1'b0;
    #1;
    check_val("b_stab_after_rst", int'(u_b.stab_q), 0);
    check_val("b_level_after_rst", int'(level_b), 0);
    check_val("b_rise_after_rst", int'(rise_b), 0);
    expect_span(1, F_LEVEL, 1, 2, 8'd0, "b_inrst_level");
    expect_span(1, F_RISE,  1, 2, 8'd0, "b_inrst_rise");
    step(2);
    rst_b_n = 1'b1;
    expect_span(1, F_LEVEL, 1, 17, 8'd0, "b_post_level");
    expect_span(1, F_LEVEL, 18, 19, 8'd1, "b_post_level");
    expect_span(1, F_RISE,  1, 17, 8'd0, "b_post_rise");
    expect_span(1, F_RISE,  18, 18, 8'd1, "b_post_rise");
    expect_span(1, F_RISE,  19, 19, 8'd0, "b_post_rise");
    expect_span(1, F_CNT,   17, 17, exp_cnt(0), "b_post_cnt");
    expect_span(1, F_CNT,   18, 18, exp_cnt(1), "b_post_cnt");
    step(19);

    check_val("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
